// File: rtl/fifo_umbral_pkg.sv
// Shared sizing constants and threshold defaults for the fifo_umbral FIFO.
package fifo_umbral_pkg;

  localparam int unsigned DATA_W_DEFAULT = 6;
  localparam int unsigned ADDR_W_DEFAULT = 3;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

  function automatic int unsigned af_default(input int unsigned addr_w);
    return depth_of(addr_w) - 32'd1;
  endfunction

  localparam int unsigned DEPTH      = depth_of(ADDR_W_DEFAULT);
  localparam int unsigned PTR_W      = ADDR_W_DEFAULT;
  localparam int unsigned CNT_W      = cnt_width(ADDR_W_DEFAULT);
  localparam int unsigned AF_DEFAULT = af_default(ADDR_W_DEFAULT);
  localparam int unsigned AE_DEFAULT = 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, registered read port.
module fifo_mem
  import fifo_umbral_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned ENTRIES = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [ENTRIES];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-address write on a full FIFO
  // still returns the oldest word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_OCCUPANCY_EN to expose the registered count on port occupancy.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_af,
  input  logic [ADDR_W:0]   umbral_ae,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              fifo_write,
  output logic              fifo_read,
  output logic              error
`ifdef FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_W:0]   occupancy
`endif
);

  localparam int unsigned ENTRIES = depth_of(ADDR_W);
  localparam int unsigned CW      = cnt_width(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic [CW-1:0]     af_q;
  logic [CW-1:0]     ae_q;
  logic              full_c;
  logic              empty_c;
  logic              push_ok_c;
  logic              pop_ok_c;
  logic              err_c;

  // Acceptance and next occupancy, all from pre-edge state.
  always_comb begin
    empty_c   = (count == '0);
    full_c    = (count == CW'(ENTRIES));
    pop_ok_c  = pop & ~empty_c;
    push_ok_c = push & (~full_c | pop_ok_c);
    err_c     = (push & ~push_ok_c) | (pop & empty_c);
    count_nxt = count;
    case ({push_ok_c, pop_ok_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count_nxt;
    end
  end

  // Newly loaded thresholds only influence flags from the following edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      af_q <= CW'(af_default(ADDR_W));
      ae_q <= CW'(AE_DEFAULT);
    end else if (init) begin
      af_q <= umbral_af;
      ae_q <= umbral_ae;
    end
  end

  // Status flags reflect post-operation occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      fifo_write   <= 1'b0;
      fifo_read    <= 1'b0;
      data_valid   <= 1'b0;
      error        <= 1'b0;
    end else begin
      fifo_full    <= (count_nxt == CW'(ENTRIES));
      fifo_empty   <= (count_nxt == '0);
      almost_full  <= (count_nxt >= af_q);
      almost_empty <= (count_nxt <= ae_q);
      fifo_write   <= push_ok_c;
      fifo_read    <= pop_ok_c;
      data_valid   <= pop_ok_c;
      error        <= error | err_c;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok_c),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (pop_ok_c),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

`ifdef FIFO_OCCUPANCY_EN
  assign occupancy = count;
`endif

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: reference model plus data scoreboard.
module tb_fifo_umbral;
  import fifo_umbral_pkg::*;

  localparam int unsigned DW = DATA_W_DEFAULT;
  localparam int unsigned CW = CNT_W;

  logic          clk;
  logic          reset;
  logic          init;
  logic [CW-1:0] umbral_af;
  logic [CW-1:0] umbral_ae;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          almost_full;
  logic          almost_empty;
  logic          fifo_write;
  logic          fifo_read;
  logic          error;
`ifdef FIFO_OCCUPANCY_EN
  logic [CW-1:0] occupancy;
`endif

  fifo_umbral dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_af    (umbral_af),
    .umbral_ae    (umbral_ae),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_write   (fifo_write),
    .fifo_read    (fifo_read),
    .error        (error)
`ifdef FIFO_OCCUPANCY_EN
    ,
    .occupancy    (occupancy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int            m_count;
  logic [CW-1:0] m_af;
  logic [CW-1:0] m_ae;
  bit            m_err;
  bit            e_wr;
  bit            e_rd;
  bit            e_af;
  bit            e_ae;
  logic [DW-1:0] exp_do;
  logic [DW-1:0] sb[$];

  // One clock: drive at negedge, model the edge, compare 1ns after posedge.
  task automatic step(input bit rst, input bit ini, input bit p, input logic [DW-1:0] d,
                      input bit q);
    bit pok;
    bit wok;
    logic [DW-1:0] v;
    @(negedge clk);
    reset   = ~rst;
    init    = ini;
    push    = p;
    data_in = d;
    pop     = q;
    if (rst) begin
      m_count = 0;
      sb.delete();
      m_af   = CW'(AF_DEFAULT);
      m_ae   = CW'(AE_DEFAULT);
      m_err  = 1'b0;
      e_wr   = 1'b0;
      e_rd   = 1'b0;
      exp_do = '0;
    end else begin
      pok = q && (m_count != 0);
      wok = p && ((m_count != int'(DEPTH)) || pok);
      if ((p && !wok) || (q && m_count == 0)) m_err = 1'b1;
      e_wr = wok;
      e_rd = pok;
      if (wok) sb.push_back(d);
      m_count = m_count + int'(wok) - int'(pok);
    end
    e_af = (m_count >= int'(m_af));
    e_ae = (m_count <= int'(m_ae));
    if (!rst && ini) begin
      m_af = umbral_af;
      m_ae = umbral_ae;
    end
    @(posedge clk);
    #1;
    check("data_valid", 32'(data_valid), 32'(e_rd));
    check("fifo_read", 32'(fifo_read), 32'(e_rd));
    check("fifo_write", 32'(fifo_write), 32'(e_wr));
    check("fifo_empty", 32'(fifo_empty), 32'(m_count == 0));
    check("fifo_full", 32'(fifo_full), 32'(m_count == int'(DEPTH)));
    check("almost_full", 32'(almost_full), 32'(e_af));
    check("almost_empty", 32'(almost_empty), 32'(e_ae));
    check("error", 32'(error), 32'(m_err));
`ifdef FIFO_OCCUPANCY_EN
    check("occupancy", 32'(occupancy), 32'(m_count));
`endif
    if (e_rd) begin
      if (sb.size() == 0) begin
        check("sb_underrun", 32'd1, 32'd0);
      end else begin
        v = sb.pop_front();
        exp_do = v;
      end
    end
    check("data_out", 32'(data_out), 32'(exp_do));
  endtask

  logic [DW-1:0] last_word;

  initial begin
    reset     = 1'b0;
    init      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    data_in   = '0;
    umbral_af = '0;
    umbral_ae = '0;

    // 1: reset, then fill with 0x01..0x08
    step(1, 0, 0, '0, 0);
    step(1, 0, 0, '0, 0);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, DW'(i), 0);
    check("t1_full", 32'(fifo_full), 32'd1);

    // 2: overflow while full, then drain in order
    step(0, 0, 1, 6'h3F, 0);
    check("t2_overflow_err", 32'(error), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, '0, 1);
      check("t2_order", 32'(data_out), 32'(i));
    end
    check("t2_empty", 32'(fifo_empty), 32'd1);

    // 3: underflow right after reset
    step(1, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    check("t3_underflow_err", 32'(error), 32'd1);

    // 4: programmed thresholds af=4 ae=2
    step(1, 0, 0, '0, 0);
    umbral_af = CW'(4);
    umbral_ae = CW'(2);
    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, DW'(8'h10 + i), 0);
    check("t4_af", 32'(almost_full), 32'd1);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 1);
    check("t4_ae", 32'(almost_empty), 32'd1);

    // 5: push+pop when full, 0x2A drains last
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, DW'(8'h20 + i), 0);
    step(0, 0, 1, 6'h2A, 1);
    check("t5_oldest", 32'(data_out), 32'h20);
    check("t5_full", 32'(fifo_full), 32'd1);
    check("t5_no_err", 32'(error), 32'd0);
    last_word = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, '0, 1);
      last_word = data_out;
    end
    check("t5_last", 32'(last_word), 32'h2A);

    // 6: reset mid-traffic, then pop on the emptied FIFO
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, DW'(8'h30 + i), 0);
    step(1, 1, 1, 6'h15, 1);
    check("t6_rst_empty", 32'(fifo_empty), 32'd1);
    check("t6_rst_dout", 32'(data_out), 32'd0);
    step(0, 0, 0, '0, 1);
    check("t6_err", 32'(error), 32'd1);
    check("t6_no_valid", 32'(data_valid), 32'd0);

    // Boundary thresholds: af beyond depth never fires, ae=0 tracks empty
    step(1, 0, 0, '0, 0);
    umbral_af = CW'(9);
    umbral_ae = CW'(0);
    step(0, 1, 0, '0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, DW'(i + 1), 0);
    check("af9_never", 32'(almost_full), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1);
    check("ae0_empty", 32'(almost_empty), 32'd1);

    // Random traffic with occasional threshold reloads
    step(1, 0, 0, '0, 0);
    for (int i = 0; i < 300; i++) begin
      umbral_af = CW'($urandom_range(0, 9));
      umbral_ae = CW'($urandom_range(0, 8));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), DW'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
- Synchronous FIFO with programmable almost-full/almost-empty thresholds.
- Sits directly upstream of the link control state machine.
- Supplies that machine's FifoFull, FifoEmpty, FifoWrite and FifoRead inputs.
- Supplies almost_full/almost_empty flags as flow-control hints to the producer.
- Latches threshold configuration while the control machine is initialising (init high).

Parameters:
DATA_W, 6, payload width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (8)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low
init  in  1  high: load umbral_af/umbral_ae into threshold registers
umbral_af  in  ADDR_W+1  almost-full threshold value
umbral_ae  in  ADDR_W+1  almost-empty threshold value
push  in  1  write request
data_in  in  DATA_W  write data
pop  in  1  read request
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out holds a newly popped word this cycle
fifo_full  out  1  count == DEPTH
fifo_empty  out  1  count == 0
almost_full  out  1  count >= af threshold
almost_empty  out  1  count <= ae threshold
fifo_write  out  1  a push was accepted at the last edge
fifo_read  out  1  a pop was accepted at the last edge
error  out  1  sticky overflow/underflow flag

Behaviour:
- Reset is synchronous and active-low on clk; clock is clk.
- Reset values:
  - wr_ptr, rd_ptr, count = 0
  - fifo_empty = 1, fifo_full = 0, almost_empty = 1, almost_full = 0
  - fifo_write = fifo_read = data_valid = error = 0
  - data_out = 0
  - af threshold = DEPTH-1, ae threshold = 1
  - Memory contents are not reset.
- Reset wins over every other input in the same cycle.
- Pointers are ADDR_W bits and wrap modulo DEPTH. count is ADDR_W+1 bits, range 0..DEPTH.
- Acceptance rules, evaluated on pre-edge state:
  - push_ok = push & (~full | pop_ok)
  - pop_ok = pop & ~empty
  - No empty bypass: pushing and popping on an empty FIFO accepts the push and rejects the pop.
- Count update:
  - push_ok only: count+1
  - pop_ok only: count-1
  - both: count unchanged
  - Full with push+pop: both accepted, fifo_full stays 1.
- Read latency is 1 cycle. On a pop_ok edge, data_out gets mem[rd_ptr] and data_valid=1 for that one cycle. Otherwise data_valid=0 and data_out holds its last value.
- fifo_write and fifo_read are registered copies of push_ok and pop_ok.
- Status flags are registered from the next count, so they reflect the post-operation occupancy in the cycle after the edge.
- Error conditions:
  - Overflow: push & ~push_ok (data is dropped).
  - Underflow: pop & empty.
  - Either sets error=1; it stays 1 until reset.
- Thresholds:
  - Loaded when init=1 at an edge; they take effect from the next edge.
  - Loading is allowed during traffic. The flags are not recomputed until the next edge.
  - af > DEPTH means almost_full never asserts. ae = 0 means almost_empty equals empty.

Optional Feature:
- Macro: FIFO_OCCUPANCY_EN.
- When defined, adds output port occupancy [ADDR_W:0], equal to the registered count and reset to 0.
- When undefined, the port is absent and count is internal only. All other behaviour is identical.

Decomposition:
- Package fifo_umbral_pkg holds:
  - DEPTH derivation
  - default thresholds AF_DEFAULT = DEPTH-1 and AE_DEFAULT = 1
  - count/pointer width constants
- Sub-module fifo_mem: DEPTH x DATA_W register array.
  - Synchronous write port (we, waddr, wdata).
  - Registered read port (re, raddr, rdata).
  - Pointer, count, flag and threshold logic stays in fifo_umbral.

Test Plan:
1. Reset, then push 0x01..0x08 on 8 consecutive cycles:
   - fifo_empty=0 after the 1st edge.
   - almost_full=1 after the 7th edge.
   - fifo_full=1 after the 8th edge.
   - fifo_write=1 on each of those 8 cycles.
2. With the FIFO full, push 0x3F:
   - fifo_write=0 and error=1; count stays 8.
   - Then 8 pops return 0x01..0x08 in order, each with data_valid=1 one cycle after the pop.
   - fifo_empty=1 after the last pop.
3. Pop on an empty FIFO right after reset:
   - error=1, fifo_read=0, data_valid=0, fifo_empty stays 1.
4. init=1 with umbral_af=4, umbral_ae=2, then 4 pushes:
   - almost_full=1 after the 4th edge.
   - After 2 pops (count 2), almost_empty=1.
5. FIFO full, simultaneous push 0x2A and pop:
   - data_out = oldest word, fifo_full stays 1, error=0.
   - 0x2A is read out last on full drain.
6. count=5, drive reset=0 for one edge:
   - All outputs take their reset values.
   - A following pop sets error=1 with data_valid=0.
